vp_pattern_gen: RTL and testbench

Video source for the DVP video-processing chain. It generates frame timing and pixel data on the vs/de/24-bit stream interface that the VP filters consume. It sits at the head of the filter pipeline for bring-up and bench stimulus, so filters can be exercised without a camera. It drives 4 selectable test patterns, and the pattern can be switched at frame boundaries.

---
 rtl/vp_pkg.sv | 54 +++++
 rtl/vp_pattern_gen_if.sv | 9 +
 rtl/vp_timing_cnt.sv | 48 ++++
 rtl/vp_pattern_gen.sv | 154 +++++++++++++++
 tb/tb_vp_pattern_gen.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/vp_pkg.sv
// Shared definitions for the vp_pattern_gen video source: pattern codes, colour-bar table,
// FSM state encoding and the bar position stepper.
package vp_pkg;

  localparam int unsigned CW = 12;
  localparam int unsigned DW = 24;
  localparam int unsigned FW = 16;

  typedef enum logic [1:0] {
    PAT_BARS  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_SOLID = 2'd3
  } pat_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [DW-1:0] BAR_RGB [8] = '{
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  // Bar position: x within the line, pixel within the bar, bar index (8 = right-edge remainder)
  typedef struct packed {
    logic [CW-1:0] xp;
    logic [CW-1:0] pix;
    logic [3:0]    idx;
  } bar_st_t;

  // Advance one pixel, wrapping at the end of the active width
  function automatic bar_st_t bar_step(input bar_st_t s, input logic [CW-1:0] hdisp,
                                       input logic [CW-1:0] bar_w);
    bar_st_t n;
    n = s;
    if (s.xp == hdisp - 12'd1) begin
      n = '0;
    end else begin
      n.xp = s.xp + 12'd1;
      if (s.idx != 4'd8) begin
        if (s.pix == bar_w - 12'd1) begin
          n.pix = '0;
          n.idx = s.idx + 4'd1;
        end else begin
          n.pix = s.pix + 12'd1;
        end
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/vp_pattern_gen_if.sv
// vs/de/24-bit pixel stream between VP pipeline stages.
interface vp_pattern_gen_if;
  logic        post_vs;
  logic        post_de;
  logic [23:0] post_data;

  modport master (output post_vs, output post_de, output post_data);
  modport slave  (input  post_vs, input  post_de, input  post_data);
endinterface

// File: rtl/vp_timing_cnt.sv
// Horizontal/vertical raster counters with vs/de decode and an end-of-frame pulse.
module vp_timing_cnt
  import vp_pkg::*;
#(
  parameter logic [CW-1:0] IMG_HDISP = 12'd1280,
  parameter logic [CW-1:0] IMG_VDISP = 12'd720,
  parameter logic [CW-1:0] H_BLANK   = 12'd160,
  parameter logic [CW-1:0] V_BLANK   = 12'd30,
  parameter logic [CW-1:0] VS_LINES  = 12'd5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          adv,
  output logic [CW-1:0] h_cnt,
  output logic [CW-1:0] v_cnt,
  output logic          line_end_c,
  output logic          eof_c,
  output logic          vs_c,
  output logic          de_c
);

  localparam logic [CW-1:0] H_MAX = IMG_HDISP + H_BLANK - 12'd1;
  localparam logic [CW-1:0] V_MAX = V_BLANK + IMG_VDISP - 12'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (clr) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (adv) begin
      if (h_cnt == H_MAX) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 12'd1;
      end else begin
        h_cnt <= h_cnt + 12'd1;
      end
    end
  end

  assign line_end_c = adv && (h_cnt == H_MAX);
  assign eof_c      = line_end_c && (v_cnt == V_MAX);
  assign vs_c       = (v_cnt < VS_LINES);
  assign de_c       = (v_cnt >= V_BLANK) && (h_cnt < IMG_HDISP);

endmodule

// File: rtl/vp_pattern_gen.sv
// Test-pattern video source: frame FSM, pattern mux and registered stream outputs.
// Define VP_PATGEN_SCROLL_EN to scroll patterns 0-2 horizontally by frame_cnt[7:0].
module vp_pattern_gen
  import vp_pkg::*;
#(
  parameter logic [CW-1:0] IMG_HDISP  = 12'd1280,
  parameter logic [CW-1:0] IMG_VDISP  = 12'd720,
  parameter logic [CW-1:0] H_BLANK    = 12'd160,
  parameter logic [CW-1:0] V_BLANK    = 12'd30,
  parameter logic [CW-1:0] VS_LINES   = 12'd5,
  parameter logic [2:0]    CHECK_LOG2 = 3'd5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              EN,
  input  logic [1:0]        mode,
  input  logic [DW-1:0]     solid_color,
  vp_pattern_gen_if.master  vid,
  output logic [FW-1:0]     frame_cnt,
  output logic              busy
);

  localparam logic [CW-1:0] BAR_W = IMG_HDISP / 12'd8;
  localparam int unsigned   CHK   = 32'(CHECK_LOG2);

  state_t        state_q, state_d;
  logic          clr_c, latch_c, run_c;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          line_end_c, eof_c, vs_c, de_c;
  pat_t          mode_q;
  logic [DW-1:0] color_q;
  bar_st_t       bar_q, start_q, start_nxt_c;
  logic [CW-1:0] x_c, y_c;
  logic          chk_c;
  logic [DW-1:0] pix_c;
  logic          vs_q, de_q;
  logic [DW-1:0] data_q;

  assign run_c = (state_q == RUN);

  vp_timing_cnt #(
    .IMG_HDISP (IMG_HDISP),
    .IMG_VDISP (IMG_VDISP),
    .H_BLANK   (H_BLANK),
    .V_BLANK   (V_BLANK),
    .VS_LINES  (VS_LINES)
  ) u_timing (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (clr_c),
    .adv        (run_c),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .line_end_c (line_end_c),
    .eof_c      (eof_c),
    .vs_c       (vs_c),
    .de_c       (de_c)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Frames always run to completion; EN is only examined at frame boundaries
  always_comb begin
    state_d = state_q;
    clr_c   = 1'b0;
    latch_c = 1'b0;
    unique case (state_q)
      IDLE: if (EN) begin
        state_d = RUN;
        clr_c   = 1'b1;
        latch_c = 1'b1;
      end
      RUN: if (eof_c) begin
        if (EN) latch_c = 1'b1;
        else    state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VP_PATGEN_SCROLL_EN
  // Line-start bar position tracks frame_cnt[7:0] mod IMG_HDISP, stepped once per frame
  assign x_c         = h_cnt + CW'(frame_cnt[7:0]);
  assign start_nxt_c = (frame_cnt[7:0] == 8'hFF) ? '0 : bar_step(start_q, IMG_HDISP, BAR_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     start_q <= '0;
    else if (eof_c) start_q <= start_nxt_c;
  end
`else
  assign x_c         = h_cnt;
  assign start_q     = '0;
  assign start_nxt_c = '0;
`endif

  // Bar sub-counter runs in step with h_cnt so no divide is needed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          bar_q <= '0;
    else if (clr_c)      bar_q <= start_q;
    else if (eof_c)      bar_q <= start_nxt_c;
    else if (line_end_c) bar_q <= start_q;
    else if (run_c)      bar_q <= bar_step(bar_q, IMG_HDISP, BAR_W);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= PAT_BARS;
      color_q   <= '0;
      frame_cnt <= '0;
    end else begin
      if (latch_c) begin
        mode_q  <= pat_t'(mode);
        color_q <= solid_color;
      end
      if (eof_c) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  assign y_c   = v_cnt - V_BLANK;
  assign chk_c = |((x_c ^ y_c) & (CW'(1) << CHK));

  always_comb begin
    pix_c = '0;
    unique case (mode_q)
      PAT_BARS:  pix_c = bar_q.idx[3] ? 24'h000000 : BAR_RGB[bar_q.idx[2:0]];
      PAT_RAMP:  pix_c = {3{x_c[7:0]}};
      PAT_CHECK: pix_c = chk_c ? 24'h000000 : 24'hFFFFFF;
      PAT_SOLID: pix_c = color_q;
      default:   pix_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q   <= 1'b0;
      de_q   <= 1'b0;
      data_q <= '0;
      busy   <= 1'b0;
    end else begin
      vs_q   <= run_c && vs_c;
      de_q   <= run_c && de_c;
      data_q <= (run_c && de_c) ? pix_c : '0;
      busy   <= (state_d == RUN);
    end
  end

  assign vid.post_vs   = vs_q;
  assign vid.post_de   = de_q;
  assign vid.post_data = data_q;

endmodule

// File: tb/tb_vp_pattern_gen.sv
// Randomized self-checking bench for vp_pattern_gen against a frame-position reference model.
module tb_vp_pattern_gen;

  localparam int HD    = 16;
  localparam int VD    = 4;
  localparam int HB    = 4;
  localparam int VB    = 2;
  localparam int VSL   = 1;
  localparam int CL    = 1;
  localparam int LINE  = HD + HB;
  localparam int FRAME = LINE * (VB + VD);
`ifdef VP_PATGEN_SCROLL_EN
  localparam int SCROLL = 1;
`else
  localparam int SCROLL = 0;
`endif

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] solid_color;
  logic [15:0] frame_cnt;
  logic        busy;

  vp_pattern_gen_if vif ();

  vp_pattern_gen #(
    .IMG_HDISP  (12'd16),
    .IMG_VDISP  (12'd4),
    .H_BLANK    (12'd4),
    .V_BLANK    (12'd2),
    .VS_LINES   (12'd1),
    .CHECK_LOG2 (3'd1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .EN          (en),
    .mode        (mode),
    .solid_color (solid_color),
    .vid         (vif),
    .frame_cnt   (frame_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  // Reference model: a single position within the frame timeline
  bit          m_run;
  int          m_pos;
  int          m_fc;
  logic [1:0]  m_mode;
  logic [23:0] m_color;
  logic        e_vs, e_de, e_busy;
  logic [23:0] e_data;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    if (obs !== expv) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, obs, expv);
    end
  endtask

  function automatic logic [23:0] ref_pixel(input logic [1:0] md, input logic [23:0] col,
                                            input int x, input int y, input int fc);
    int xs;
    int b;
    xs = x + SCROLL * (fc % 256);
    case (md)
      2'd0: begin
        b = (xs % HD) / (HD / 8);
        return (b < 8) ? bars[b] : 24'h0;
      end
      2'd1: return {3{8'(xs)}};
      2'd2: return ((((xs >> CL) ^ (y >> CL)) & 1) != 0) ? 24'h000000 : 24'hFFFFFF;
      default: return col;
    endcase
  endfunction

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_fc = 0; m_mode = 0; m_color = 0;
    e_vs = 0; e_de = 0; e_data = 0; e_busy = 0;
  endtask

  // Outputs after this edge reflect the position before it; then the position advances
  task automatic model_step();
    int x, ln;
    if (m_run) begin
      x      = m_pos % LINE;
      ln     = m_pos / LINE;
      e_vs   = (ln < VSL);
      e_de   = (ln >= VB) && (x < HD);
      e_data = e_de ? ref_pixel(m_mode, m_color, x, ln - VB, m_fc) : 24'h0;
    end else begin
      e_vs = 0; e_de = 0; e_data = 0;
    end
    if (!m_run) begin
      if (en) begin
        m_run = 1; m_pos = 0; m_mode = mode; m_color = solid_color;
      end
    end else if (m_pos == FRAME - 1) begin
      m_fc  = (m_fc + 1) % 65536;
      m_pos = 0;
      if (en) begin
        m_mode = mode; m_color = solid_color;
      end else begin
        m_run = 0;
      end
    end else begin
      m_pos++;
    end
    e_busy = m_run;
  endtask

  task automatic compare_all();
    check_eq("post_vs",   32'(vif.post_vs),   32'(e_vs));
    check_eq("post_de",   32'(vif.post_de),   32'(e_de));
    check_eq("post_data", 32'(vif.post_data), 32'(e_data));
    check_eq("busy",      32'(busy),          32'(e_busy));
    check_eq("frame_cnt", 32'(frame_cnt),     32'(m_fc));
  endtask

  // Called at a falling edge; returns at a falling edge
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      model_step();
      #1;
      compare_all();
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    bit found;
    clk = 0; rst_n = 0; en = 0; mode = 0; solid_color = 0;
    model_reset();
    #1 compare_all();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    step(3);

    // colour bars, then ramp and checker (mode changes land mid-frame)
    en = 1; mode = 2'd0;
    step(2 * FRAME + 7);
    mode = 2'd1;
    step(2 * FRAME);
    mode = 2'd2;
    step(2 * FRAME);

    // solid colour changed mid-frame
    mode = 2'd3; solid_color = 24'h123456;
    step(FRAME + 40);
    solid_color = 24'hABCDEF;
    step(2 * FRAME);

    // drop EN at position 50 of a frame, let it drain, then restart
    found = 0;
    for (int i = 0; i < 2 * FRAME && !found; i++) begin
      if (m_run && m_pos == 50) found = 1;
      else step(1);
    end
    check_eq("pos50_reached", 32'(found), 32'd1);
    en = 0;
    step(FRAME);
    en = 1; mode = 2'd0;
    step(FRAME + 10);

    // asynchronous reset mid-line, restart with EN held high
    step(37);
    do_reset();
    mode = 2'd2;
    step(2 * FRAME + 5);

    // randomized mode / colour / EN / reset traffic
    for (int it = 0; it < 30; it++) begin
      int r;
      int n;
      r    = int'($urandom_range(0, 9));
      mode = 2'($urandom_range(0, 3));
      solid_color = 24'($urandom);
      n    = int'($urandom_range(20, 260));
      if (r == 0) do_reset();
      en = (r > 2);
      step(n / 2);
      solid_color = 24'($urandom);
      if (r == 9) mode = 2'($urandom_range(0, 3));
      step(n - n / 2);
    end

    en = 0;
    step(FRAME + 5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
